// File: rtl/tick_generator.sv
// Multi-channel fractional tick generator behind a simple memory-mapped bus.
// Each channel emits one-cycle enables whose average period is D/2^FRAC_WIDTH cycles.
module tick_generator #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int FRAC_WIDTH  = 8,
    parameter int DEFAULT_DIV = 217
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);

    localparam int W = DIV_WIDTH + FRAC_WIDTH;
    localparam logic [W:0]   ONE       = {{DIV_WIDTH{1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
    localparam logic [W-1:0] DIV_RST   = W'(DEFAULT_DIV) << FRAC_WIDTH;
    localparam logic [7:0]   SYNC_ADDR = 8'(8 * NUM_CH);

    logic [NUM_CH-1:0] en;
    logic [W-1:0]      div_q [NUM_CH];
    logic [W-1:0]      acc   [NUM_CH];
    logic [15:0]       cnt   [NUM_CH];

    logic [W:0]        sum   [NUM_CH];
    logic [W:0]        de    [NUM_CH];
    logic [NUM_CH-1:0] hit;

    logic [7:0]        addr;
    logic [4:0]        sel_ch;
    logic [2:0]        sel_off;
    logic              wr;
    logic              wr_sync;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_div;
    logic [31:0]       rd_val;
    logic              unused;

    // Divisors below one cycle are clamped so an integer part of 0 ticks every cycle.
    function automatic logic [W:0] eff_div(input logic [W-1:0] dv);
        logic [W:0] wide;
        wide = {1'b0, dv};
        return (wide < ONE) ? ONE : wide;
    endfunction

    assign addr    = mem_addr[7:0];
    assign sel_ch  = addr[7:3];
    assign sel_off = addr[2:0];
    assign wr      = mem_valid && (mem_wstrb != 4'b0000);
    assign wr_sync = wr && (addr == SYNC_ADDR);
    assign active  = en;
    assign unused  = ^{mem_addr[31:8], mem_wdata};

    always_comb begin
        hit     = '0;
        wr_ctrl = '0;
        wr_div  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            sum[n]     = {1'b0, acc[n]} + ONE;
            de[n]      = eff_div(div_q[n]);
            hit[n]     = (sum[n] >= de[n]);
            wr_ctrl[n] = wr && (sel_ch == 5'(n)) && (sel_off == 3'd0);
            wr_div[n]  = wr && (sel_ch == 5'(n)) && (sel_off == 3'd4);
        end
    end

    always_comb begin
        rd_val = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (sel_ch == 5'(n)) begin
                if (sel_off == 3'd0) begin
                    rd_val = {cnt[n], 15'b0, en[n]};
                end else if (sel_off == 3'd4) begin
                    rd_val = 32'(div_q[n]);
                end
            end
        end
    end

    // Bus writes are applied after the accumulator step so a write always wins on its edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            en   <= '0;
            tick <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                div_q[n] <= DIV_RST;
                acc[n]   <= '0;
                cnt[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (en[n]) begin
                    if (hit[n]) begin
                        acc[n]  <= W'(sum[n] - de[n]);
                        tick[n] <= 1'b1;
                        cnt[n]  <= cnt[n] + 16'd1;
                    end else begin
                        acc[n]  <= sum[n][W-1:0];
                        tick[n] <= 1'b0;
                    end
                end else begin
                    tick[n] <= 1'b0;
                end
                if (wr_ctrl[n]) begin
                    en[n]  <= mem_wdata[0];
                    cnt[n] <= '0;
                    if (mem_wdata[0]) begin
                        acc[n] <= '0;
                    end
                end
                if (wr_div[n]) begin
                    div_q[n] <= mem_wdata[W-1:0];
                    acc[n]   <= '0;
                end
                if (wr_sync) begin
                    acc[n] <= '0;
                end
            end
        end
    end

    // Every request is answered on the following cycle; data reflects pre-edge state.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= mem_valid;
            mem_rdata <= mem_valid ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: bus reads go through a response scoreboard,
// tick patterns are compared cycle by cycle against hand-derived tables.
module tb_tick_generator;

    localparam int NUM_CH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              mem_valid;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    logic [31:0] mon_exp;
    bit          mon_chk;

    always #5 clock = ~clock;

    tick_generator #(
        .NUM_CH(NUM_CH),
        .DIV_WIDTH(16),
        .FRAC_WIDTH(8),
        .DEFAULT_DIV(217)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_valid(mem_valid),
        .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .tick(tick),
        .active(active)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        mem_valid = 1'b1;
        mem_wstrb = 4'hF;
        mem_addr  = {24'h0, a};
        mem_wdata = d;
        exp_q.push_back(32'h0);
        chk_q.push_back(1'b0);
        cyc();
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] exp);
        mem_valid = 1'b1;
        mem_wstrb = 4'h0;
        mem_addr  = {24'h0, a};
        mem_wdata = 32'h0;
        exp_q.push_back(exp);
        chk_q.push_back(1'b1);
        cyc();
        mem_valid = 1'b0;
    endtask

    // Response monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=1 expected=0");
            end else begin
                mon_exp = exp_q.pop_front();
                mon_chk = chk_q.pop_front();
                if (mon_chk) begin
                    checks++;
                    if (mem_rdata !== mon_exp) begin
                        errors++;
                        $display("FAIL read_data actual=%h expected=%h", mem_rdata, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat1;
        pat1 = 16'h0528;   // ticks at cycles 3,5,8,10 for a 2.5 divisor

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_ready", 32'(mem_ready), 32'h0);
        check("reset_active", 32'(active), 32'h0);
        bus_read(8'h04, 32'h0000D900);
        bus_read(8'h00, 32'h00000000);

        // Channel 0, divisor 3.0
        bus_write(8'h04, 32'h00000300);
        bus_write(8'h00, 32'h00000001);
        check("ch0_active", 32'(active), 32'h1);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            check($sformatf("ch0_tick_c%0d", k), 32'(tick), (k % 3 == 0) ? 32'h1 : 32'h0);
        end
        bus_read(8'h00, 32'h000A0001);
        bus_write(8'h00, 32'h00000000);

        // Channel 1, divisor 2.5
        bus_write(8'h0C, 32'h00000280);
        bus_write(8'h08, 32'h00000001);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check($sformatf("ch1_tick_c%0d", k), 32'(tick), {30'b0, pat1[k], 1'b0});
        end
        bus_read(8'h08, 32'h00040001);
        bus_write(8'h08, 32'h00000000);

        // Channel 2, integer part 0 ticks every cycle
        bus_write(8'h14, 32'h00000040);
        bus_write(8'h10, 32'h00000001);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check($sformatf("ch2_tick_c%0d", k), 32'(tick), 32'h4);
        end
        bus_write(8'h10, 32'h00000000);
        check("ch2_active_off", 32'(active), 32'h0);
        cyc();
        check("ch2_tick_off1", 32'(tick), 32'h0);
        cyc();
        check("ch2_tick_off2", 32'(tick), 32'h0);
        bus_read(8'h10, 32'h00000000);
        bus_read(8'h14, 32'h00000040);

        // Channels 0 and 3 at 4.0, two cycles apart, then SYNC
        bus_write(8'h04, 32'h00000400);
        bus_write(8'h1C, 32'h00000400);
        bus_write(8'h00, 32'h00000001);
        cyc();
        bus_write(8'h18, 32'h00000001);
        bus_write(8'h20, 32'h0000DEAD);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check($sformatf("sync_tick_c%0d", k), 32'(tick), (k % 4 == 0) ? 32'h9 : 32'h0);
        end
        repeat (3) cyc();
        bus_write(8'h00, 32'h00000001);
        check("ctrl_edge_tick", 32'(tick), 32'h9);
        bus_read(8'h00, 32'h00000001);
        bus_read(8'h18, 32'h00030001);
        cyc();
        bus_read(8'h18, 32'h00030001);
        bus_read(8'h18, 32'h00040001);
        bus_read(8'h20, 32'h00000000);

        // Reset dominates a same-cycle write
        reset     = 1'b1;
        mem_valid = 1'b1;
        mem_wstrb = 4'hF;
        mem_addr  = 32'h08;
        mem_wdata = 32'h1;
        cyc();
        reset     = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        check("rst_wr_ready", 32'(mem_ready), 32'h0);
        check("rst_wr_active", 32'(active), 32'h0);
        check("rst_wr_tick", 32'(tick), 32'h0);
        cyc();
        check("rst_wr_tick2", 32'(tick), 32'h0);
        check("rst_wr_active2", 32'(active), 32'h0);
        bus_read(8'hF0, 32'h00000000);
        bus_read(8'h08, 32'h00000000);
        bus_read(8'h04, 32'h0000D900);
        cyc();
        cyc();
        check("idle_rdata", mem_rdata, 32'h0);
        check("idle_ready", 32'(mem_ready), 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        check("responses_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
